// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - pipeline-side bundle for the iterative RV64M unit
//
// Signals (directions seen from the unit, i.e. the slave modport):
//   muldiv_i_valid     in   execute stage holds an M-extension instruction
//   muldiv_i_alu_info  in   one-hot op select, bit 12 mul ... bit 0 remuw
//   muldiv_i_src1/2    in   rs1 / rs2 data
//   muldiv_i_flush     in   redirect, kill the operation in flight
//   muldiv_o_stall     out  freeze the pipeline
//   muldiv_o_valid     out  one-cycle result pulse
//   muldiv_o_result    out  result, held until the next accept
//   muldiv_o_busy      out  unit is not idle
interface muldiv_ctrl_if;
    logic        muldiv_i_valid;
    logic [12:0] muldiv_i_alu_info;
    logic [63:0] muldiv_i_src1;
    logic [63:0] muldiv_i_src2;
    logic        muldiv_i_flush;
    logic        muldiv_o_stall;
    logic        muldiv_o_valid;
    logic [63:0] muldiv_o_result;
    logic        muldiv_o_busy;

    modport master (
        output muldiv_i_valid, muldiv_i_alu_info, muldiv_i_src1, muldiv_i_src2, muldiv_i_flush,
        input  muldiv_o_stall, muldiv_o_valid, muldiv_o_result, muldiv_o_busy
    );

    modport slave (
        input  muldiv_i_valid, muldiv_i_alu_info, muldiv_i_src1, muldiv_i_src2, muldiv_i_flush,
        output muldiv_o_stall, muldiv_o_valid, muldiv_o_result, muldiv_o_busy
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative RV64M multiply/divide unit and sequencer
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   muldiv_if  slave side of muldiv_ctrl_if (request, flush, stall, result)
//
// One 128-bit working register is shared by a shift-add multiplier and a
// restoring divider, both retiring one bit per cycle. Operands are reduced to
// magnitudes in PREP and the signs are reapplied in FIX.
module muldiv_ctrl #(
    parameter int XLEN = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_ctrl_if.slave  muldiv_if
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [12:0]         op_q, op_d;
    logic [XLEN-1:0]     src1_q, src1_d;
    logic [XLEN-1:0]     src2_q, src2_d;
    logic [XLEN-1:0]     opb_q, opb_d;        // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   work_q, work_d;      // {hi/rem, lo/quo}
    logic [5:0]          cnt_q, cnt_d;
    logic                neg_res_q, neg_res_d; // negate product / quotient
    logic                neg_rem_q, neg_rem_d; // negate remainder
    logic [XLEN-1:0]     result_q, result_d;
    logic                valid_q, valid_d;

    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

    // Op decode from the latched one-hot vector
    logic is_w, is_mul, is_rem, s1_signed, s2_signed;
    assign is_w      = op_q[0] | op_q[1] | op_q[4] | op_q[5] | op_q[8];
    assign is_mul    = |op_q[12:8];
    assign is_rem    = |op_q[3:0];
    assign s2_signed = op_q[12] | op_q[11] | op_q[8] | op_q[7] | op_q[5] | op_q[3] | op_q[1];
    // mulhsu treats only rs1 as signed
    assign s1_signed = s2_signed | op_q[10];

    // PREP: operand extension, magnitudes and division special cases
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, spec_res;
    logic            a_neg, b_neg, div_zero, div_ovf;
    assign a_ext    = is_w ? {{(XLEN-32){s1_signed & src1_q[31]}}, src1_q[31:0]} : src1_q;
    assign b_ext    = is_w ? {{(XLEN-32){s2_signed & src2_q[31]}}, src2_q[31:0]} : src2_q;
    assign a_neg    = s1_signed & a_ext[XLEN-1];
    assign b_neg    = s2_signed & b_ext[XLEN-1];
    assign a_mag    = a_neg ? -a_ext : a_ext;
    assign b_mag    = b_neg ? -b_ext : b_ext;
    assign div_zero = ~is_mul & (b_ext == '0);
    assign div_ovf  = ~is_mul & s2_signed & (b_ext == '1)
                    & (a_ext == (is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    // Divide by zero: quo = ~0, rem = dividend. Overflow: quo = dividend, rem = 0.
    always_comb begin
        spec_res = '0;
        if (is_rem) spec_res = div_zero ? a_ext : '0;
        else        spec_res = div_zero ? '1 : a_ext;
        if (is_w)   spec_res = sext_w(spec_res);
    end

    // CALC: one multiply step (add then shift right) and one restoring divide step
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, div_next;
    logic [XLEN:0]     rem_sh, div_diff;
    assign mul_sum  = {1'b0, work_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
    assign mul_next = work_q[0] ? {mul_sum, work_q[XLEN-1:1]} : {1'b0, work_q[2*XLEN-1:1]};
    // Shifted remainder needs XLEN+1 bits; since rem < divisor the difference bit XLEN is a borrow.
    assign rem_sh   = work_q[2*XLEN-1:XLEN-1];
    assign div_diff = rem_sh - {1'b0, opb_q};
    assign div_next = div_diff[XLEN] ? {work_q[2*XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], work_q[XLEN-2:0], 1'b1};

    // FIX: sign correction and result selection
    logic [2*XLEN-1:0] prod_raw, prod;
    logic [XLEN-1:0]   quo, rem, fix_res;
    // W multiplies run 32 steps, leaving the product 32 bits up in the register
    assign prod_raw = is_w ? {32'b0, work_q[2*XLEN-1:32]} : work_q;
    assign prod     = neg_res_q ? -prod_raw : prod_raw;
    assign quo      = neg_res_q ? -work_q[XLEN-1:0] : work_q[XLEN-1:0];
    assign rem      = neg_rem_q ? -work_q[2*XLEN-1:XLEN] : work_q[2*XLEN-1:XLEN];
    always_comb begin
        fix_res = '0;
        if (is_mul) begin
            if (op_q[12])     fix_res = prod[XLEN-1:0];
            else if (op_q[8]) fix_res = sext_w(prod[XLEN-1:0]);
            else              fix_res = prod[2*XLEN-1:XLEN];
        end else begin
            fix_res = is_rem ? rem : quo;
            if (is_w) fix_res = sext_w(fix_res);
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        opb_d     = opb_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        valid_d   = 1'b0;
        if (state_q != S_IDLE && muldiv_if.muldiv_i_flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (muldiv_if.muldiv_i_valid && (|muldiv_if.muldiv_i_alu_info)
                        && !muldiv_if.muldiv_i_flush) begin
                        op_d    = muldiv_if.muldiv_i_alu_info;
                        src1_d  = muldiv_if.muldiv_i_src1;
                        src2_d  = muldiv_if.muldiv_i_src2;
                        state_d = S_PREP;
                    end
                end
                S_PREP: begin
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = is_w ? 6'd31 : 6'd63;
                    if (is_mul) begin
                        work_d  = {{XLEN{1'b0}}, b_mag};
                        opb_d   = a_mag;
                        state_d = S_CALC;
                    end else if (div_zero || div_ovf) begin
                        result_d = spec_res;
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        // W dividends sit in the top half so 32 shifts consume them fully
                        work_d  = {{XLEN{1'b0}}, (is_w ? {a_mag[31:0], 32'b0} : a_mag)};
                        opb_d   = b_mag;
                        state_d = S_CALC;
                    end
                end
                S_CALC: begin
                    work_d = is_mul ? mul_next : div_next;
                    if (cnt_q == 6'd0) state_d = S_FIX;
                    else               cnt_d   = cnt_q - 6'd1;
                end
                S_FIX: begin
                    result_d = fix_res;
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            opb_q     <= '0;
            work_q    <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            opb_q     <= opb_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
        end
    end

    assign muldiv_if.muldiv_o_stall  = muldiv_if.muldiv_i_valid & (|muldiv_if.muldiv_i_alu_info)
                                     & ~valid_q & ~muldiv_if.muldiv_i_flush;
    assign muldiv_if.muldiv_o_valid  = valid_q;
    assign muldiv_if.muldiv_o_result = result_q;
    assign muldiv_if.muldiv_o_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [63:0] last_exp;

    muldiv_ctrl_if dif();

    muldiv_ctrl #(.XLEN(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .muldiv_if (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    // Behavioural reference: plain arithmetic on the architectural definitions
    function automatic logic [63:0] model(input int op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0]       p;
        logic signed [63:0] sa, sb;
        logic [31:0]        a32, b32, r32;
        logic signed [31:0] sa32, sb32;
        logic [63:0]        r;
        sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
        r = '0; r32 = '0; p = '0;
        case (op)
            12: r = a * b;
            11: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
            10: begin p = {{64{a[63]}}, a} * {64'b0, b};       r = p[127:64]; end
            9:  begin p = {64'b0, a} * {64'b0, b};             r = p[127:64]; end
            8:  begin r32 = a32 * b32; r = {{32{r32[31]}}, r32}; end
            7:  if (b == 0) r = ONES; else if (a == MIN64 && b == ONES) r = a; else r = sa / sb;
            6:  r = (b == 0) ? ONES : a / b;
            3:  if (b == 0) r = a; else if (a == MIN64 && b == ONES) r = '0; else r = sa % sb;
            2:  r = (b == 0) ? a : a % b;
            5, 1: begin
                if (b32 == 0)                                  r32 = (op == 5) ? 32'hFFFF_FFFF : a32;
                else if (a32 == 32'h8000_0000 && b32 == '1)    r32 = (op == 5) ? a32 : 32'h0;
                else                                           r32 = (op == 5) ? sa32 / sb32 : sa32 % sb32;
                r = {{32{r32[31]}}, r32};
            end
            4, 0: begin
                if (b32 == 0) r32 = (op == 4) ? 32'hFFFF_FFFF : a32;
                else          r32 = (op == 4) ? a32 / b32 : a32 % b32;
                r = {{32{r32[31]}}, r32};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input int op, input logic [63:0] a, input logic [63:0] b);
        bit w, sgn, zero, ovf;
        w    = (op == 0 || op == 1 || op == 4 || op == 5 || op == 8);
        sgn  = (op == 1 || op == 3 || op == 5 || op == 7);
        zero = w ? (b[31:0] == 32'h0) : (b == 64'h0);
        ovf  = sgn && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                         : (a == MIN64 && b == ONES));
        if (op <= 7 && (zero || ovf)) return 2;
        return w ? 35 : 67;
    endfunction

    // Drives one instruction until its result pulse; reports result, edges from accept, stall errors
    task automatic do_op(input int op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output int lat, output int stall_bad);
        res = '0; lat = 0; stall_bad = 0;
        @(negedge clk);
        dif.muldiv_i_valid    = 1'b1;
        dif.muldiv_i_alu_info = 13'd1 << op;
        dif.muldiv_i_src1     = a;
        dif.muldiv_i_src2     = b;
        dif.muldiv_i_flush    = 1'b0;
        #1;
        if (dif.muldiv_o_stall !== 1'b1) stall_bad++;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        // operands change after accept and must be ignored
        dif.muldiv_i_src1 = {$urandom, $urandom};
        dif.muldiv_i_src2 = {$urandom, $urandom};
        while (dif.muldiv_o_valid !== 1'b1 && lat < 200) begin
            if (dif.muldiv_o_stall !== 1'b1) stall_bad++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (dif.muldiv_o_valid === 1'b1) begin
            if (dif.muldiv_o_stall !== 1'b0) stall_bad++;
            res = dif.muldiv_o_result;
        end
        dif.muldiv_i_valid    = 1'b0;
        dif.muldiv_i_alu_info = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dif.muldiv_i_valid = 1'b0; dif.muldiv_i_alu_info = '0;
        dif.muldiv_i_src1 = '0; dif.muldiv_i_src2 = '0; dif.muldiv_i_flush = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (dif.muldiv_o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", dif.muldiv_o_valid); end
        n_checks++; if (dif.muldiv_o_result !== 64'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", dif.muldiv_o_result); end
        n_checks++; if (dif.muldiv_o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", dif.muldiv_o_busy); end
        n_checks++; if (dif.muldiv_o_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", dif.muldiv_o_stall); end
        last_exp = '0;
    endtask

    task automatic test_zero_info();
        @(negedge clk);
        dif.muldiv_i_valid = 1'b1; dif.muldiv_i_alu_info = '0;
        #1;
        n_checks++; if (dif.muldiv_o_stall !== 1'b0) begin n_fail++; $display("FAIL zero_info_stall got %b want 0", dif.muldiv_o_stall); end
        @(negedge clk);
        n_checks++; if (dif.muldiv_o_busy !== 1'b0) begin n_fail++; $display("FAIL zero_info_busy got %b want 0", dif.muldiv_o_busy); end
        dif.muldiv_i_valid = 1'b0;
    endtask

    task automatic test_directed();
        int          ops [11] = '{12, 11, 9, 8, 7, 3, 4, 6, 3, 7, 3};
        logic [63:0] as  [11] = '{64'd7, MIN64, MIN64, 64'h7FFF_FFFF, -64'd7, -64'd7,
                                  64'hFFFF_FFFF, 64'd1234, 64'd5, MIN64, MIN64};
        logic [63:0] bs  [11] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 64'd2, 64'd2, 64'd2, 64'd2,
                                  64'd1, 64'd0, 64'd0, ONES, ONES};
        logic [63:0] exp [11] = '{64'hFFFF_FFFF_FFFF_FFEB, ONES, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE,
                                  64'hFFFF_FFFF_FFFF_FFFD, ONES, ONES, ONES, 64'd5, MIN64, 64'd0};
        int          lats[11] = '{67, 67, 67, 35, 67, 67, 35, 2, 2, 2, 2};
        logic [63:0] res;
        int          lat, sb;
        for (int i = 0; i < 11; i++) begin
            do_op(ops[i], as[i], bs[i], res, lat, sb);
            n_checks++; if (res !== exp[i]) begin n_fail++; $display("FAIL directed_result[%0d] op %0d got %h want %h", i, ops[i], res, exp[i]); end
            n_checks++; if (lat != lats[i]) begin n_fail++; $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, lats[i]); end
            n_checks++; if (sb != 0) begin n_fail++; $display("FAIL directed_stall[%0d] got %0d bad cycles want 0", i, sb); end
            last_exp = exp[i];
        end
    endtask

    task automatic test_random();
        logic [63:0] a, b, res, exp;
        int          op, lat, sb, mode;
        for (int i = 0; i < 26; i++) begin
            op   = $urandom_range(0, 12);
            a    = {$urandom, $urandom};
            b    = {$urandom, $urandom};
            mode = $urandom_range(0, 5);
            case (mode)
                0: b = ($urandom_range(0, 1) == 1) ? 64'h0 : {$urandom, 32'h0};
                1: b = {{60{b[63]}}, b[3:0] | 4'd1};
                2: begin a = ($urandom_range(0, 1) == 1) ? MIN64 : 64'h1234_5678_8000_0000; b = ONES; end
                3: a = {{48{a[63]}}, a[15:0]};
                default: ;
            endcase
            exp = model(op, a, b);
            do_op(op, a, b, res, lat, sb);
            n_checks++; if (res !== exp) begin n_fail++; $display("FAIL random_result[%0d] op %0d a %h b %h got %h want %h", i, op, a, b, res, exp); end
            n_checks++; if (lat != model_lat(op, a, b)) begin n_fail++; $display("FAIL random_latency[%0d] op %0d got %0d want %0d", i, op, lat, model_lat(op, a, b)); end
            n_checks++; if (sb != 0) begin n_fail++; $display("FAIL random_stall[%0d] got %0d bad cycles want 0", i, sb); end
            last_exp = exp;
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] res;
        int          lat, sb;
        do_op(8, 64'h0000_0000_0001_0003, 64'h0000_0000_FFFF_FFFF, res, lat, sb);
        n_checks++; if (res !== model(8, 64'h1_0003, 64'hFFFF_FFFF)) begin n_fail++; $display("FAIL b2b_first got %h want %h", res, model(8, 64'h1_0003, 64'hFFFF_FFFF)); end
        do_op(2, 64'd100, 64'd7, res, lat, sb);
        n_checks++; if (res !== 64'd2) begin n_fail++; $display("FAIL b2b_second got %h want 2", res); end
        n_checks++; if (lat != 67) begin n_fail++; $display("FAIL b2b_latency got %0d want 67", lat); end
        last_exp = 64'd2;
    endtask

    task automatic test_flush();
        logic [63:0] res;
        int          lat, sb, seen;
        @(negedge clk);
        dif.muldiv_i_valid = 1'b1; dif.muldiv_i_alu_info = 13'd1 << 12;
        dif.muldiv_i_src1 = {$urandom, $urandom}; dif.muldiv_i_src2 = {$urandom, $urandom};
        @(posedge clk);               // accept, enter PREP
        @(posedge clk);               // enter CALC cycle 1
        repeat (9) @(posedge clk);    // CALC cycle 10
        @(negedge clk);
        dif.muldiv_i_flush = 1'b1;
        #1;
        n_checks++; if (dif.muldiv_o_stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b want 0", dif.muldiv_o_stall); end
        n_checks++; if (dif.muldiv_o_busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before got %b want 1", dif.muldiv_o_busy); end
        @(negedge clk);
        n_checks++; if (dif.muldiv_o_busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_after got %b want 0", dif.muldiv_o_busy); end
        n_checks++; if (dif.muldiv_o_result !== last_exp) begin n_fail++; $display("FAIL flush_result_held got %h want %h", dif.muldiv_o_result, last_exp); end
        dif.muldiv_i_flush = 1'b0; dif.muldiv_i_valid = 1'b0; dif.muldiv_i_alu_info = '0;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (dif.muldiv_o_valid === 1'b1) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL flush_no_valid got %0d pulses want 0", seen); end
        do_op(12, 64'd3, 64'd4, res, lat, sb);
        n_checks++; if (res !== 64'd12) begin n_fail++; $display("FAIL flush_followup_result got %h want c", res); end
        n_checks++; if (lat != 67) begin n_fail++; $display("FAIL flush_followup_latency got %0d want 67", lat); end
        last_exp = 64'd12;
    endtask

    task automatic test_reset_mid();
        logic [63:0] res, a, b;
        int          lat, sb;
        @(negedge clk);
        dif.muldiv_i_valid = 1'b1; dif.muldiv_i_alu_info = 13'd1 << 7;
        dif.muldiv_i_src1 = {$urandom, $urandom}; dif.muldiv_i_src2 = 64'd13;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        dif.muldiv_i_valid = 1'b0; dif.muldiv_i_alu_info = '0;
        #1;
        n_checks++; if (dif.muldiv_o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", dif.muldiv_o_busy); end
        n_checks++; if (dif.muldiv_o_result !== 64'h0) begin n_fail++; $display("FAIL rstmid_result got %h want 0", dif.muldiv_o_result); end
        n_checks++; if (dif.muldiv_o_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0", dif.muldiv_o_valid); end
        n_checks++; if (dif.muldiv_o_stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall got %b want 0", dif.muldiv_o_stall); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (dif.muldiv_o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle got %b want 0", dif.muldiv_o_busy); end
        a = {$urandom, $urandom};
        b = {32'h0, $urandom} | 64'd1;
        do_op(3, a, b, res, lat, sb);
        n_checks++; if (res !== model(3, a, b)) begin n_fail++; $display("FAIL rstmid_first_op got %h want %h", res, model(3, a, b)); end
        n_checks++; if (lat != 67) begin n_fail++; $display("FAIL rstmid_latency got %0d want 67", lat); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_zero_info();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
